// File: rtl/dense_train_ctrl.sv
// Step sequencer for dense_layer training: zero-grad plus first forward, overlapped
// forward/backward per sample, final backward, then weight update. All outputs are registered.
module dense_train_ctrl #(
    parameter int BATCH_SIZE = 4,
    parameter int TIMEOUT    = 4096,
    parameter int IDX_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             valid_forward,
    input  logic             valid_backward,
    input  logic             valid_zero_grad,
    input  logic             valid_update,
    output logic             zero_grad,
    output logic             run_forward,
    output logic             run_backward,
    output logic             load_backward,
    output logic             update,
    output logic [IDX_W-1:0] fwd_idx,
    output logic [IDX_W-1:0] bwd_idx,
    output logic             busy,
    output logic             done,
    output logic             error
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BATCH_SIZE - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_S1_SET, ST_S1_RUN, ST_LOAD, ST_S2_SET,
        ST_S2_RUN, ST_S3_SET, ST_S3_RUN, ST_UPD, ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] fwd_idx_q, fwd_idx_d, bwd_idx_q, bwd_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             f_seen_q, f_seen_d, z_seen_q, z_seen_d, b_seen_q, b_seen_d;
    logic             error_q, error_d, timeout_s;
    logic             zero_grad_q, zero_grad_d, run_forward_q, run_forward_d;
    logic             run_backward_q, run_backward_d, load_backward_q, load_backward_d;
    logic             update_q, update_d, busy_q, busy_d, done_q, done_d;

    // Next-state, sticky-flag, index and timeout logic
    always_comb begin
        state_d   = state_q;
        fwd_idx_d = fwd_idx_q;
        bwd_idx_d = bwd_idx_q;
        f_seen_d  = f_seen_q;
        z_seen_d  = z_seen_q;
        b_seen_d  = b_seen_q;
        error_d   = error_q;
        cnt_d     = {CNT_W{1'b0}};
        timeout_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    error_d   = 1'b0;
                    fwd_idx_d = {IDX_W{1'b0}};
                    bwd_idx_d = {IDX_W{1'b0}};
                    state_d   = ST_S1_SET;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_S1_SET: state_d = ST_S1_RUN;
            ST_S1_RUN: begin
                cnt_d    = cnt_q + CNT_ONE;
                f_seen_d = f_seen_q | valid_forward;
                z_seen_d = z_seen_q | valid_zero_grad;
                if (f_seen_d && z_seen_d) begin
                    state_d = ST_LOAD;
                end else begin
                    timeout_s = (cnt_q == CNT_LAST);
                end
            end
            ST_LOAD: begin
                if (fwd_idx_q < LAST_IDX) begin
                    fwd_idx_d = fwd_idx_q + IDX_ONE;
                    bwd_idx_d = fwd_idx_q;
                    state_d   = ST_S2_SET;
                end else begin
                    bwd_idx_d = LAST_IDX;
                    state_d   = ST_S3_SET;
                end
            end
            ST_S2_SET: state_d = ST_S2_RUN;
            ST_S2_RUN: begin
                cnt_d    = cnt_q + CNT_ONE;
                f_seen_d = f_seen_q | valid_forward;
                b_seen_d = b_seen_q | valid_backward;
                if (f_seen_d && b_seen_d) begin
                    state_d = ST_LOAD;
                end else begin
                    timeout_s = (cnt_q == CNT_LAST);
                end
            end
            ST_S3_SET: state_d = ST_S3_RUN;
            ST_S3_RUN: begin
                cnt_d = cnt_q + CNT_ONE;
                if (valid_backward) begin
                    state_d = ST_UPD;
                end else begin
                    timeout_s = (cnt_q == CNT_LAST);
                end
            end
            ST_UPD: begin
                cnt_d = cnt_q + CNT_ONE;
                if (valid_update) begin
                    state_d = ST_DONE;
                end else begin
                    timeout_s = (cnt_q == CNT_LAST);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (timeout_s) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
        end else begin
            error_d = error_d;
        end

        // Abort overrides everything, including a start arriving in IDLE
        if (abort) begin
            state_d   = ST_IDLE;
            error_d   = error_q;
            fwd_idx_d = fwd_idx_q;
            bwd_idx_d = bwd_idx_q;
        end else begin
            state_d = state_d;
        end

        if (state_d != state_q) begin
            f_seen_d = 1'b0;
            z_seen_d = 1'b0;
            b_seen_d = 1'b0;
            cnt_d    = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_d;
        end
    end

    // Output decode from the upcoming state so every control leaves a flop
    always_comb begin
        zero_grad_d     = (state_d == ST_S1_SET) || ((state_d == ST_S1_RUN) && !z_seen_d);
        run_forward_d   = ((state_d == ST_S1_RUN) || (state_d == ST_S2_RUN)) && !f_seen_d;
        run_backward_d  = ((state_d == ST_S2_RUN) && !b_seen_d) || (state_d == ST_S3_RUN);
        load_backward_d = (state_d == ST_LOAD);
        update_d        = (state_d == ST_UPD);
        done_d          = (state_d == ST_DONE);
        busy_d          = (state_d != ST_IDLE);
    end

    // State, flag and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            fwd_idx_q       <= {IDX_W{1'b0}};
            bwd_idx_q       <= {IDX_W{1'b0}};
            cnt_q           <= {CNT_W{1'b0}};
            f_seen_q        <= 1'b0;
            z_seen_q        <= 1'b0;
            b_seen_q        <= 1'b0;
            error_q         <= 1'b0;
            zero_grad_q     <= 1'b0;
            run_forward_q   <= 1'b0;
            run_backward_q  <= 1'b0;
            load_backward_q <= 1'b0;
            update_q        <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            fwd_idx_q       <= fwd_idx_d;
            bwd_idx_q       <= bwd_idx_d;
            cnt_q           <= cnt_d;
            f_seen_q        <= f_seen_d;
            z_seen_q        <= z_seen_d;
            b_seen_q        <= b_seen_d;
            error_q         <= error_d;
            zero_grad_q     <= zero_grad_d;
            run_forward_q   <= run_forward_d;
            run_backward_q  <= run_backward_d;
            load_backward_q <= load_backward_d;
            update_q        <= update_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign zero_grad     = zero_grad_q;
    assign run_forward   = run_forward_q;
    assign run_backward  = run_backward_q;
    assign load_backward = load_backward_q;
    assign update        = update_q;
    assign fwd_idx       = fwd_idx_q;
    assign bwd_idx       = bwd_idx_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
endmodule

// File: tb/tb_dense_train_ctrl.sv
// Bench for dense_train_ctrl: a BATCH_SIZE=2 and a BATCH_SIZE=1 instance (TIMEOUT=16) driven by a
// delay-programmable dense_layer responder, with a table of whole-step cases plus corner sequences.
module tb_dense_train_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_s [2];
    logic       abort_s [2];
    logic       vv      [2][4];
    logic       zg [2], rf [2], rb [2], lb [2], upd [2], bsy [2], dn [2], er [2];
    logic [7:0] fi [2], bi [2];

    int errors = 0;
    int checks = 0;
    int dly [4];
    int cnt [2][4];

    typedef struct {
        int dut; int fd; int zd; int bd; int ud;
        int exp_end; int exp_loads; int exp_dones; int exp_err; int exp_bwd; int exp_ovl;
    } case_t;
    case_t tbl [7];
    case_t sb [$];

    always #5 clk = ~clk;

    dense_train_ctrl #(.BATCH_SIZE(2), .TIMEOUT(16), .IDX_W(8)) dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .abort(abort_s[0]),
        .valid_forward(vv[0][1]), .valid_backward(vv[0][2]),
        .valid_zero_grad(vv[0][0]), .valid_update(vv[0][3]),
        .zero_grad(zg[0]), .run_forward(rf[0]), .run_backward(rb[0]),
        .load_backward(lb[0]), .update(upd[0]), .fwd_idx(fi[0]), .bwd_idx(bi[0]),
        .busy(bsy[0]), .done(dn[0]), .error(er[0]));

    dense_train_ctrl #(.BATCH_SIZE(1), .TIMEOUT(16), .IDX_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .abort(abort_s[1]),
        .valid_forward(vv[1][1]), .valid_backward(vv[1][2]),
        .valid_zero_grad(vv[1][0]), .valid_update(vv[1][3]),
        .zero_grad(zg[1]), .run_forward(rf[1]), .run_backward(rb[1]),
        .load_backward(lb[1]), .update(upd[1]), .fwd_idx(fi[1]), .bwd_idx(bi[1]),
        .busy(bsy[1]), .done(dn[1]), .error(er[1]));

    function automatic logic ctl_of(int d, int k);
        case (k)
            0:       return zg[d];
            1:       return rf[d];
            2:       return rb[d];
            default: return upd[d];
        endcase
    endfunction

    // dense_layer stand-in: a control held high for dly cycles yields a one-cycle valid (0 = never)
    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                if (rst) begin
                    cnt[d][k] <= 0;
                    vv[d][k]  <= 1'b0;
                end else if (ctl_of(d, k) && dly[k] != 0) begin
                    cnt[d][k] <= cnt[d][k] + 1;
                    vv[d][k]  <= (cnt[d][k] + 1 == dly[k]);
                end else begin
                    cnt[d][k] <= 0;
                    vv[d][k]  <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs(int d);
        return {zg[d], rf[d], rb[d], lb[d], upd[d], bsy[d], dn[d], er[d], |fi[d], |bi[d]};
    endfunction

    // Runs one table row: the expected record is queued at start and compared when the step ends
    task automatic run_case(input case_t c);
        int d, end_at, loads, dones, ovl, bwd_end, err_end;
        case_t e;
        d = c.dut;
        dly[0] = c.zd; dly[1] = c.fd; dly[2] = c.bd; dly[3] = c.ud;
        sb.push_back(c);
        end_at = -1; loads = 0; dones = 0; ovl = 0; bwd_end = -1; err_end = -1;
        @(negedge clk); start_s[d] = 1'b1;
        @(negedge clk); start_s[d] = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (k == 0) check("err_clr_on_start", int'(er[d]), 0);
            if (lb[d]) loads++;
            if (dn[d]) dones++;
            if (rf[d] && rb[d]) begin
                ovl++;
                check("s2_bwd_eq_fwd_minus1", int'(bi[d]), int'(fi[d]) - 1);
            end
            if (!bsy[d]) begin
                end_at = k; bwd_end = int'(bi[d]); err_end = int'(er[d]);
                break;
            end
            @(negedge clk);
        end
        e = sb.pop_front();
        check("step_end_cycle", end_at, e.exp_end);
        check("load_pulses", loads, e.exp_loads);
        check("done_pulses", dones, e.exp_dones);
        check("error_at_end", err_end, e.exp_err);
        check("bwd_idx_at_end", bwd_end, e.exp_bwd);
        check("fwd_bwd_overlap", ovl, e.exp_ovl);
    endtask

    initial begin
        int got;
        start_s[0] = 1'b0; start_s[1] = 1'b0; abort_s[0] = 1'b0; abort_s[1] = 1'b0;
        for (int k = 0; k < 4; k++) dly[k] = 5;
        //          dut fd zd bd ud end loads dones err bwd ovl
        tbl[0] = '{0, 5, 5, 5, 5, 30, 2, 1, 0, 1, 6};
        tbl[1] = '{0, 2, 7, 4, 1, 25, 2, 1, 0, 1, 3};
        tbl[2] = '{0, 5, 5, 5, 0, 39, 2, 0, 1, 1, 6};
        tbl[3] = '{0, 3, 1, 9, 2, 33, 2, 1, 0, 1, 4};
        tbl[4] = '{1, 0, 2, 5, 5, 17, 0, 0, 1, 0, 0};
        tbl[5] = '{1, 5, 5, 5, 5, 22, 1, 1, 0, 0, 0};
        tbl[6] = '{1, 1, 2, 3, 4, 15, 1, 1, 0, 0, 0};

        repeat (2) @(negedge clk);
        check("reset_outs_dut0", outs(0), 0);
        check("reset_outs_dut1", outs(1), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_case(tbl[i]);

        // Abort during S2_RUN, then restart from S1 with fwd_idx back at 0
        for (int k = 0; k < 4; k++) dly[k] = 8;
        @(negedge clk); start_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0;
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            if (rf[0] && rb[0]) got = 1; else @(negedge clk);
        end
        check("reach_s2_run", got, 1);
        check("s2_fwd_idx", int'(fi[0]), 1);
        abort_s[0] = 1'b1;
        @(negedge clk); abort_s[0] = 1'b0;
        check("abort_controls", {zg[0], rf[0], rb[0], lb[0], upd[0], dn[0], bsy[0]}, 0);
        check("abort_error_kept", int'(er[0]), 0);
        start_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0;
        check("restart_zero_grad", {zg[0], rf[0], bsy[0]}, 3'b101);
        check("restart_fwd_idx", int'(fi[0]), 0);
        @(negedge clk);
        check("restart_run_forward", {zg[0], rf[0]}, 2'b11);
        abort_s[0] = 1'b1;
        @(negedge clk); abort_s[0] = 1'b0;
        check("abort_busy_low", int'(bsy[0]), 0);

        // Asynchronous reset in the middle of S1_RUN
        @(negedge clk); start_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0;
        @(negedge clk);
        check("s1_run_active", {zg[0], rf[0]}, 2'b11);
        #3 rst = 1'b1;
        #1 check("async_reset_outs", outs(0), 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("post_reset_idle", outs(0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
